// File: rtl/note_meter_pkg.sv
// Shared types and default sizing for the note period meter.
package note_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } meter_state_t;

  localparam int                   DEF_CNT_W        = 28;
  localparam logic [DEF_CNT_W-1:0] DEF_TIMEOUT      = 28'd10_000_000;
  localparam int                   DEF_DEGLITCH_LEN = 4;

endpackage

// File: rtl/tone_edge_sync.sv
// Synchronizes the asynchronous tone, optionally filters it (NOTE_METER_DEGLITCH_EN),
// and produces registered one-cycle rise/fall pulses.
module tone_edge_sync
  import note_meter_pkg::*;
`ifdef NOTE_METER_DEGLITCH_EN
#(
  parameter int DEGLITCH_LEN = DEF_DEGLITCH_LEN
)
`endif
(
  input  logic clock_in,
  input  logic reset,
  input  logic tone_in,
  output logic rise,
  output logic fall
);

  logic sync_q1;
  logic sync_q2;
  logic level;
  logic level_q;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= tone_in;
      sync_q2 <= sync_q1;
    end
  end

`ifdef NOTE_METER_DEGLITCH_EN
  localparam int DG_W = (DEGLITCH_LEN > 1) ? $clog2(DEGLITCH_LEN) : 1;

  logic [DG_W-1:0] stable_cnt;
  logic            filtered;

  // The filtered level follows only after DEGLITCH_LEN consecutive differing samples.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      filtered   <= 1'b0;
      stable_cnt <= '0;
    end else if (sync_q2 == filtered) begin
      stable_cnt <= '0;
    end else if (stable_cnt == DG_W'(DEGLITCH_LEN - 1)) begin
      filtered   <= sync_q2;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign level = filtered;
`else
  assign level = sync_q2;
`endif

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      level_q <= level;
      rise    <= level & ~level_q;
      fall    <= ~level & level_q;
    end
  end

endmodule

// File: rtl/note_period_meter.sv
// Measures period and high time of an asynchronous tone in system clock cycles.
// Optional input deglitch filter is enabled with NOTE_METER_DEGLITCH_EN.
module note_period_meter
  import note_meter_pkg::*;
#(
  parameter int             CNT_W        = DEF_CNT_W,
  parameter logic [CNT_W-1:0] TIMEOUT    = CNT_W'(DEF_TIMEOUT),
  parameter int             DEGLITCH_LEN = DEF_DEGLITCH_LEN
)
(
  input  logic             clock_in,
  input  logic             reset,
  input  logic             tone_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             no_signal
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("note_period_meter: TIMEOUT must be at least 2");
  end
  if (DEGLITCH_LEN < 1) begin : g_bad_deglitch
    $error("note_period_meter: DEGLITCH_LEN must be at least 1");
  end

  localparam logic [CNT_W-1:0] LAST_COUNT = TIMEOUT - 1'b1;
  localparam logic [CNT_W-1:0] ONE_CNT    = CNT_W'(1);

  logic rise;
  logic fall;

`ifdef NOTE_METER_DEGLITCH_EN
  tone_edge_sync #(.DEGLITCH_LEN(DEGLITCH_LEN)) u_edge (
`else
  tone_edge_sync u_edge (
`endif
    .clock_in (clock_in),
    .reset    (reset),
    .tone_in  (tone_in),
    .rise     (rise),
    .fall     (fall)
  );

  meter_state_t     state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic [CNT_W-1:0] high_capture, high_capture_next;
  logic             fall_seen, fall_seen_next;
  logic [CNT_W-1:0] period_next, high_time_next;
  logic             period_valid_next, no_signal_next;
  logic             timeout;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      high_capture <= '0;
      fall_seen    <= 1'b0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      no_signal    <= 1'b1;
    end else begin
      state        <= state_next;
      count        <= count_next;
      high_capture <= high_capture_next;
      fall_seen    <= fall_seen_next;
      period       <= period_next;
      high_time    <= high_time_next;
      period_valid <= period_valid_next;
      no_signal    <= no_signal_next;
    end
  end

  assign timeout = (count == LAST_COUNT);

  // A rise always beats a simultaneous timeout; a period with no fall reports high_time = period.
  always_comb begin
    state_next        = state;
    count_next        = count;
    high_capture_next = high_capture;
    fall_seen_next    = fall_seen;
    period_next       = period;
    high_time_next    = high_time;
    period_valid_next = 1'b0;
    no_signal_next    = no_signal;

    if (!enable) begin
      state_next     = IDLE;
      count_next     = '0;
      no_signal_next = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          count_next     = '0;
          no_signal_next = 1'b1;
          state_next     = ARM;
        end
        ARM: begin
          if (rise) begin
            count_next     = ONE_CNT;
            fall_seen_next = 1'b0;
            state_next     = MEASURE;
          end else if (timeout) begin
            count_next     = '0;
            no_signal_next = 1'b1;
            period_next    = '0;
            high_time_next = '0;
          end else begin
            count_next = count + ONE_CNT;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_next       = count;
            high_time_next    = fall_seen ? high_capture : count;
            period_valid_next = 1'b1;
            no_signal_next    = 1'b0;
            count_next        = ONE_CNT;
            fall_seen_next    = 1'b0;
          end else if (timeout) begin
            count_next     = '0;
            no_signal_next = 1'b1;
            period_next    = '0;
            high_time_next = '0;
            state_next     = ARM;
          end else begin
            count_next = count + ONE_CNT;
            if (fall) begin
              high_capture_next = count;
              fall_seen_next    = 1'b1;
            end
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_period_meter.sv
// Self-checking bench for note_period_meter: randomized tone shapes checked
// against an edge-timestamp model of period/high-time reporting.
module tb_note_period_meter;

  localparam int CNT_W     = 16;
  localparam int TIMEOUT_I = 1500;
  localparam int DG_LEN    = 4;
`ifdef NOTE_METER_DEGLITCH_EN
  localparam int MIN_LEN = DG_LEN;
`else
  localparam int MIN_LEN = 1;
`endif

  logic             clock_in;
  logic             reset;
  logic             tone_in;
  logic             enable;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             no_signal;

  note_period_meter #(
    .CNT_W        (CNT_W),
    .TIMEOUT      (CNT_W'(TIMEOUT_I)),
    .DEGLITCH_LEN (DG_LEN)
  ) dut (
    .clock_in     (clock_in),
    .reset        (reset),
    .tone_in      (tone_in),
    .enable       (enable),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .no_signal    (no_signal)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  int cyc = 0;
  always @(posedge clock_in) cyc = cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference model: every accepted rise closes the previous period unless the
  // gap reached TIMEOUT (the meter timed out and only re-armed on this rise).
  typedef struct {
    int per;
    int hi;
  } meas_t;

  meas_t exp_q[$];
  bit    have_prev    = 1'b0;
  bit    fall_seen_m  = 1'b0;
  int    last_rise    = 0;
  int    last_fall    = 0;
  int    push_cnt     = 0;
  int    last_per     = 0;
  int    last_hi      = 0;

  function automatic void model_rise(input int t);
    meas_t m;
    if (have_prev && (t - last_rise) <= TIMEOUT_I - 1) begin
      m.per = t - last_rise;
      m.hi  = fall_seen_m ? (last_fall - last_rise) : m.per;
      exp_q.push_back(m);
      push_cnt++;
      last_per = m.per;
      last_hi  = m.hi;
    end
    have_prev   = 1'b1;
    last_rise   = t;
    fall_seen_m = 1'b0;
  endfunction

  function automatic void model_fall(input int t);
    last_fall   = t;
    fall_seen_m = 1'b1;
  endfunction

  function automatic void model_break();
    have_prev = 1'b0;
  endfunction

  // Drives the tone at a falling clock edge and holds it for n cycles.
  task automatic drive_level(input logic v, input int n, input bit tracked);
    if (tracked && v !== tone_in) begin
      if (v) model_rise(cyc);
      else   model_fall(cyc);
    end
    tone_in = v;
    repeat (n) @(negedge clock_in);
  endtask

  task automatic apply_stimulus(input int h, input int l);
    drive_level(1'b1, h, 1'b1);
    drive_level(1'b0, l, 1'b1);
  endtask

  int valid_cnt      = 0;
  int last_valid_cyc = 0;

  always @(negedge clock_in) begin : monitor
    meas_t m;
    if (!reset && period_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        check_output("unexpected_valid", 32'd1, 32'd0);
      end else begin
        m = exp_q.pop_front();
        check_output("period", 32'(period), m.per);
        check_output("high_time", 32'(high_time), m.hi);
        check_output("no_signal_on_valid", 32'(no_signal), 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit seen;
    int hl;
    int ll;

    tone_in = 1'b0;
    enable  = 1'b0;
    reset   = 1'b1;
    #23;
    check_output("reset_period", 32'(period), 32'd0);
    check_output("reset_high_time", 32'(high_time), 32'd0);
    check_output("reset_valid", 32'(period_valid), 32'd0);
    check_output("reset_no_signal", 32'(no_signal), 32'd1);

    @(negedge clock_in);
    reset = 1'b0;
    repeat (2) @(negedge clock_in);
    check_output("idle_no_signal", 32'(no_signal), 32'd1);
    enable = 1'b1;
    @(negedge clock_in);

    $display("[TB] 25%% duty, period 20");
    apply_stimulus(5, 15);
    check_output("no_signal_before_first_valid", 32'(no_signal), 32'd1);
    repeat (4) apply_stimulus(5, 15);

    $display("[TB] random tone shapes");
    for (int i = 0; i < 25; i++) begin
      hl = $urandom_range(60, MIN_LEN);
      ll = $urandom_range(60, MIN_LEN);
      apply_stimulus(hl, ll);
    end
    drive_level(1'b0, 12, 1'b1);

    $display("[TB] rise versus timeout boundary");
    apply_stimulus(700, TIMEOUT_I - 1 - 700);
    apply_stimulus(700, TIMEOUT_I - 700);
    apply_stimulus(20, 20);
    apply_stimulus(20, 20);

    // no_signal rises TIMEOUT cycles after the last internal rise, i.e. one
    // cycle less than that after the strobe the rise produced.
    $display("[TB] tone stops");
    apply_stimulus(10, 10);
    apply_stimulus(10, 10);
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT_I + 100; i++) begin
      @(negedge clock_in);
      if (no_signal) begin
        seen = 1'b1;
        break;
      end
    end
    check_output("timeout_seen", 32'(seen), 32'd1);
    if (seen) check_output("timeout_delay", cyc - last_valid_cyc, TIMEOUT_I - 1);
    check_output("timeout_period", 32'(period), 32'd0);
    check_output("timeout_high_time", 32'(high_time), 32'd0);
    repeat (3) apply_stimulus(15, 15);

    $display("[TB] reset mid-period");
    apply_stimulus(30, 10);
    #2;
    reset = 1'b1;
    #1;
    check_output("midreset_period", 32'(period), 32'd0);
    check_output("midreset_high_time", 32'(high_time), 32'd0);
    check_output("midreset_valid", 32'(period_valid), 32'd0);
    check_output("midreset_no_signal", 32'(no_signal), 32'd1);
    model_break();
    repeat (3) @(negedge clock_in);
    reset = 1'b0;
    repeat (3) apply_stimulus(12, 8);

    $display("[TB] enable dropped mid-period");
    apply_stimulus(20, 10);
    enable = 1'b0;
    model_break();
    drive_level(1'b0, 2, 1'b1);
    check_output("disabled_no_signal", 32'(no_signal), 32'd1);
    check_output("disabled_period_hold", 32'(period), last_per);
    check_output("disabled_high_hold", 32'(high_time), last_hi);
    drive_level(1'b0, 8, 1'b1);
    enable = 1'b1;
    repeat (3) apply_stimulus(10, 10);

    $display("[TB] glitches in the low phase");
    for (int i = 0; i < 4; i++) begin
      drive_level(1'b1, 500, 1'b1);
      drive_level(1'b0, 200, 1'b1);
`ifdef NOTE_METER_DEGLITCH_EN
      drive_level(1'b1, 2, 1'b0);
      drive_level(1'b0, 298, 1'b0);
`else
      drive_level(1'b1, 2, 1'b1);
      drive_level(1'b0, 298, 1'b1);
`endif
    end
    apply_stimulus(500, 500);
    drive_level(1'b0, 20, 1'b1);

    check_output("pending_valids", exp_q.size(), 32'd0);
    check_output("valid_count", valid_cnt, push_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
